// File: rtl/mem_hit_responder.sv
// Arbitrates instruction/data requests onto one variable-latency single-port RAM and returns
// one-cycle ihit/dhit pulses. Define MEMRESP_PERF_CNT_EN to add icount/dcount hit counters.
module mem_hit_responder #(
    parameter int WORD_W      = 32,
    parameter int DSTREAK_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    input  logic              halt,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] imemload,
    output logic [WORD_W-1:0] dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramrdy,
    output logic              halted
`ifdef MEMRESP_PERF_CNT_EN
    ,
    output logic [WORD_W-1:0] icount,
    output logic [WORD_W-1:0] dcount
`endif
);
    localparam int STREAK_W = (DSTREAK_MAX < 1) ? 1 : $clog2(DSTREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DSTREAK_MAX);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] IACC   = 3'd1;
    localparam logic [2:0] DACC   = 3'd2;
    localparam logic [2:0] RESP   = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;

    logic [2:0]          state_reg;
    logic [STREAK_W-1:0] streak_reg;
    logic                is_write_reg;
    logic                halt_seen_reg;
    logic                data_req;
    logic                force_inst;
    logic                grant_data;
    logic                unused_addr_bits;

    // RAM is word addressed; byte-lane bits of the request addresses are dropped.
    assign unused_addr_bits = ^{imemaddr[1:0], dmemaddr[1:0]};

    assign data_req   = dmemREN | dmemWEN;
    assign force_inst = (DSTREAK_MAX > 0) && imemREN && (streak_reg == STREAK_MAX);
    assign grant_data = data_req && !force_inst;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            streak_reg    <= '0;
            is_write_reg  <= 1'b0;
            halt_seen_reg <= 1'b0;
            ihit          <= 1'b0;
            dhit          <= 1'b0;
            imemload      <= '0;
            dmemload      <= '0;
            ramREN        <= 1'b0;
            ramWEN        <= 1'b0;
            ramaddr       <= '0;
            ramstore      <= '0;
            halted        <= 1'b0;
`ifdef MEMRESP_PERF_CNT_EN
            icount        <= '0;
            dcount        <= '0;
`endif
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            // A halt that arrives while busy is remembered so the access can finish first.
            if (halt && (state_reg == IACC || state_reg == DACC || state_reg == RESP))
                halt_seen_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (halt) begin
                        state_reg <= HALTED;
                        halted    <= 1'b1;
                    end else if (grant_data) begin
                        state_reg    <= DACC;
                        ramaddr      <= {dmemaddr[WORD_W-1:2], 2'b00};
                        ramstore     <= dmemstore;
                        ramWEN       <= dmemWEN;
                        ramREN       <= ~dmemWEN;
                        is_write_reg <= dmemWEN;
                        if (!imemREN)
                            streak_reg <= '0;
                        else if (streak_reg != STREAK_MAX)
                            streak_reg <= streak_reg + 1'b1;
                    end else if (imemREN) begin
                        state_reg  <= IACC;
                        ramaddr    <= {imemaddr[WORD_W-1:2], 2'b00};
                        ramREN     <= 1'b1;
                        ramWEN     <= 1'b0;
                        streak_reg <= '0;
                    end
                end
                IACC: begin
                    if (ramrdy) begin
                        ramREN    <= 1'b0;
                        imemload  <= ramload;
                        ihit      <= 1'b1;
                        state_reg <= RESP;
`ifdef MEMRESP_PERF_CNT_EN
                        icount    <= icount + 1'b1;
`endif
                    end
                end
                DACC: begin
                    if (ramrdy) begin
                        ramREN    <= 1'b0;
                        ramWEN    <= 1'b0;
                        if (!is_write_reg)
                            dmemload <= ramload;
                        dhit      <= 1'b1;
                        state_reg <= RESP;
`ifdef MEMRESP_PERF_CNT_EN
                        dcount    <= dcount + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (halt || halt_seen_reg) begin
                        state_reg <= HALTED;
                        halted    <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_hit_responder.sv
// Bench for mem_hit_responder: bench-side RAM with programmable wait states, a word-level
// reference memory checked on every hit, and directed scenarios with literal expectations.
module tb_mem_hit_responder;
    logic        clk;
    logic        nrst;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        ihit;
    logic        dhit;
    logic [31:0] imemload;
    logic [31:0] dmemload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramrdy;
    logic        halted;
`ifdef MEMRESP_PERF_CNT_EN
    logic [31:0] icount;
    logic [31:0] dcount;
`endif

    int   n_total = 0;
    int   n_pass  = 0;
    int   wait_cfg;
    logic rdy_force;

    mem_hit_responder #(.WORD_W(32), .DSTREAK_MAX(4)) dut (
        .CLK(clk), .nRST(nrst),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .halt(halt), .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramrdy(ramrdy), .halted(halted)
`ifdef MEMRESP_PERF_CNT_EN
        , .icount(icount), .dcount(dcount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] preload(input int i);
        if (i == 1)  return 32'hDEAD_BEEF;
        if (i == 32) return 32'hCAFE_0080;
        return 32'h1000_0000 + 32'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Bench-side RAM: ready after wait_cfg strobe cycles; writes land on the ready edge.
    logic [31:0] mem [0:255];
    int busy;
    assign ramrdy  = rdy_force | ((ramREN | ramWEN) & (busy >= wait_cfg));
    assign ramload = mem[ramaddr[9:2]];

    initial begin
        busy <= 0;
        for (int i = 0; i < 256; i++) mem[i] <= preload(i);
        forever begin
            @(posedge clk);
            if ((ramREN | ramWEN) && !ramrdy) busy <= busy + 1;
            else busy <= 0;
            if (ramWEN && ramrdy) mem[ramaddr[9:2]] <= ramstore;
        end
    end

    // Reference model: word memory updated by completed writes; every hit, strobe and
    // hit spacing is checked against it while out of reset.
    logic [31:0] ref_mem [0:255];
    int gap;
    initial begin
        logic addr_ok;
        for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);
        gap = 99;
        forever begin
            @(posedge clk);
            #2;
            if (!nrst) begin
                gap = 99;
            end else begin
                if (ihit || dhit) begin
                    check("one_source_per_hit", 32'(ihit & dhit), 32'd0);
                    check("hit_spacing", 32'(gap >= 2), 32'd1);
                    gap = 0;
                end else if (gap < 99) begin
                    gap++;
                end
                if (ihit)
                    check("imemload_model", imemload, ref_mem[imemaddr[9:2]]);
                if (dhit && dmemWEN)
                    ref_mem[dmemaddr[9:2]] = dmemstore;
                else if (dhit)
                    check("dmemload_model", dmemload, ref_mem[dmemaddr[9:2]]);
                if (ramREN && ramWEN)
                    check("strobes_exclusive", 32'd1, 32'd0);
                if (ramWEN) begin
                    check("write_addr_model", ramaddr, {dmemaddr[31:2], 2'b00});
                    check("write_data_model", ramstore, dmemstore);
                end
                if (ramREN) begin
                    addr_ok = (imemREN && ramaddr == {imemaddr[31:2], 2'b00}) ||
                              (dmemREN && ramaddr == {dmemaddr[31:2], 2'b00});
                    check("read_addr_model", 32'(addr_ok), 32'd1);
                end
            end
        end
    end

    // Waits up to bound falling edges for a hit; snapshots strobes on the first cycle.
    task automatic wait_hit(input int bound, output int cyc, output logic got_i,
                            output logic got_d, output logic f_ren, output logic f_wen,
                            output logic [31:0] f_addr, output logic [31:0] f_store);
        cyc = 0; got_i = 0; got_d = 0; f_ren = 0; f_wen = 0; f_addr = 0; f_store = 0;
        while (cyc < bound && !got_i && !got_d) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                f_ren = ramREN; f_wen = ramWEN; f_addr = ramaddr; f_store = ramstore;
            end
            got_i = ihit;
            got_d = dhit;
        end
        if (!got_i && !got_d) check("hit_timeout", 32'(cyc), 32'(bound + 1));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ihit"}, 32'(ihit), 32'd0);
        check({tag, "_dhit"}, 32'(dhit), 32'd0);
        check({tag, "_ramREN"}, 32'(ramREN), 32'd0);
        check({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
        check({tag, "_ramaddr"}, ramaddr, 32'd0);
        check({tag, "_ramstore"}, ramstore, 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        int          cyc;
        logic        gi, gd, fr, fw;
        logic [31:0] fa, fs;
        logic [9:0]  order;
        int          activity, hcnt, bad;

        nrst = 0; imemREN = 0; imemaddr = 0; dmemREN = 0; dmemWEN = 0;
        dmemaddr = 0; dmemstore = 0; halt = 0; wait_cfg = 0; rdy_force = 0;
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        check("rst_imemload", imemload, 32'd0);
        check("rst_dmemload", dmemload, 32'd0);
        $display("txn reset: outputs cleared");

        // Unaligned instruction read, RAM ready at once.
        nrst = 1; imemREN = 1; imemaddr = 32'h6;
        wait_hit(20, cyc, gi, gd, fr, fw, fa, fs);
        check("t1_ihit", 32'(gi), 32'd1);
        check("t1_latency", 32'(cyc), 32'd2);
        check("t1_ramREN", 32'(fr), 32'd1);
        check("t1_ramaddr", fa, 32'h4);
        check("t1_imemload", imemload, 32'hDEAD_BEEF);
        $display("txn ifetch addr=0x6 latency=%0d load=0x%08h", cyc, imemload);
        imemREN = 0;
        @(negedge clk);
        check("t1_ihit_width", 32'(ihit), 32'd0);

        // Instruction and write together: write wins, then the instruction read.
        imemREN = 1; imemaddr = 32'h100;
        dmemWEN = 1; dmemaddr = 32'h40; dmemstore = 32'h1234; wait_cfg = 3;
        wait_hit(30, cyc, gi, gd, fr, fw, fa, fs);
        check("t2_dhit_first", 32'(gd), 32'd1);
        check("t2_latency", 32'(cyc), 32'd5);
        check("t2_ramWEN", 32'(fw), 32'd1);
        check("t2_ramREN", 32'(fr), 32'd0);
        check("t2_ramaddr", fa, 32'h40);
        check("t2_ramstore", fs, 32'h1234);
        $display("txn write addr=0x40 data=0x1234 latency=%0d", cyc);
        dmemWEN = 0; wait_cfg = 0;
        wait_hit(30, cyc, gi, gd, fr, fw, fa, fs);
        check("t2_ihit_next", 32'(gi), 32'd1);
        check("t2_spacing", 32'(cyc), 32'd3);
        check("t2_imemload", imemload, 32'h1000_0040);
        $display("txn ifetch addr=0x100 spacing=%0d load=0x%08h", cyc, imemload);
        imemREN = 0;

        // Both sources held: data streaks of four, then a forced instruction grant.
        imemREN = 1; imemaddr = 32'h8; dmemREN = 1; dmemaddr = 32'h40;
        order = '0;
        for (int k = 0; k < 10; k++) begin
            wait_hit(30, cyc, gi, gd, fr, fw, fa, fs);
            order[k] = gi;
            if (k == 0) check("t3_first_dmemload", dmemload, 32'h1234);
            $display("txn streak grant %0d: %s", k, gi ? "I" : "D");
        end
        check("t3_grant_order", 32'(order), 32'h210);
        imemREN = 0; dmemREN = 0;

        // Halt pulse during a data read: the read completes, then nothing more.
        dmemREN = 1; dmemaddr = 32'h80; wait_cfg = 4;
        repeat (2) @(negedge clk);
        halt = 1;
        @(negedge clk);
        halt = 0;
        wait_hit(30, cyc, gi, gd, fr, fw, fa, fs);
        check("t4_dhit", 32'(gd), 32'd1);
        check("t4_dmemload", dmemload, 32'hCAFE_0080);
        $display("txn read addr=0x80 under halt load=0x%08h", dmemload);
        dmemREN = 0; imemREN = 1; imemaddr = 32'h0; wait_cfg = 0;
        activity = 0; hcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ramREN || ramWEN || ihit || dhit) activity++;
            if (halted) hcnt++;
        end
        check("t4_no_activity", 32'(activity), 32'd0);
        check("t4_halted_cycles", 32'(hcnt), 32'd20);
        $display("txn halted: activity=%0d halted_cycles=%0d", activity, hcnt);

        // Async reset in the middle of a write access.
        nrst = 0; imemREN = 0;
        @(negedge clk);
        check_reset_state("rst2");
        nrst = 1; dmemWEN = 1; dmemaddr = 32'hC0; dmemstore = 32'h5555; wait_cfg = 10;
        @(negedge clk);
        check("t5_ramWEN_before", 32'(ramWEN), 32'd1);
        #3;
        nrst = 0;
        #1;
        check_reset_state("t5_async");
        $display("txn async reset mid-write: ramWEN=%0b halted=%0b", ramWEN, halted);
        @(negedge clk);
        dmemWEN = 0; nrst = 1; wait_cfg = 0; imemREN = 1; imemaddr = 32'h6;
        wait_hit(20, cyc, gi, gd, fr, fw, fa, fs);
        check("t5_ihit", 32'(gi), 32'd1);
        check("t5_latency", 32'(cyc), 32'd2);
        check("t5_imemload", imemload, 32'hDEAD_BEEF);
        $display("txn ifetch after reset latency=%0d load=0x%08h", cyc, imemload);
        imemREN = 0;

        // Stray ramrdy while idle must not produce a hit.
        @(negedge clk);
        rdy_force = 1;
        activity = 0;
        repeat (3) begin
            @(negedge clk);
            if (ihit || dhit) activity++;
        end
        rdy_force = 0;
        check("stray_rdy_no_hit", 32'(activity), 32'd0);
        $display("txn stray ramrdy: hits=%0d", activity);

`ifdef MEMRESP_PERF_CNT_EN
        nrst = 0;
        @(negedge clk);
        nrst = 1;
        check("t6_icount_reset", icount, 32'd0);
        for (int i = 0; i < 7; i++) begin
            imemREN = 1; imemaddr = 32'(4 * i);
            wait_hit(20, cyc, gi, gd, fr, fw, fa, fs);
            imemREN = 0;
        end
        for (int i = 0; i < 3; i++) begin
            dmemREN = 1; dmemaddr = 32'h40;
            wait_hit(20, cyc, gi, gd, fr, fw, fa, fs);
            dmemREN = 0;
        end
        halt = 1;
        repeat (2) @(negedge clk);
        check("t6_icount", icount, 32'd7);
        check("t6_dcount", dcount, 32'd3);
        imemREN = 1; bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (icount != 32'd7 || dcount != 32'd3) bad++;
        end
        check("t6_counts_frozen", 32'(bad), 32'd0);
        $display("txn perf counters icount=%0d dcount=%0d", icount, dcount);
        imemREN = 0; halt = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end
endmodule
